// File: rtl/data_mem_dma.sv
// Block-transfer initiator for the 32x16 data memory: COPY moves LEN words src->dst,
// FILL writes a constant to LEN words. Owns the memory port only while busy.
module data_mem_dma #(
    parameter int AW = 5,
    parameter int DW = 16,
    parameter int LW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_value,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] words_left,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_datain,
    input  logic [DW-1:0] mem_dataout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LEN_ONE = LW'(1);
    localparam logic [LW-1:0] LEN_ZERO = LW'(0);

    state_t        state_r, state_s;
    logic          mode_r, mode_s;
    logic [AW-1:0] src_ptr_r, src_ptr_s;
    logic [AW-1:0] dst_ptr_r, dst_ptr_s;
    logic [LW-1:0] words_left_r, words_left_s;
    logic [DW-1:0] buf_r, buf_s;
    logic [DW-1:0] fill_r, fill_s;

    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          mem_write_r, mem_write_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [DW-1:0] mem_datain_r, mem_datain_s;

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        state_s      = state_r;
        mode_s       = mode_r;
        src_ptr_s    = src_ptr_r;
        dst_ptr_s    = dst_ptr_r;
        words_left_s = words_left_r;
        buf_s        = buf_r;
        fill_s       = fill_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mode_s       = mode;
                    src_ptr_s    = src_addr;
                    dst_ptr_s    = dst_addr;
                    words_left_s = len;
                    fill_s       = fill_value;
                    if (len == LEN_ZERO) begin
                        state_s = ST_DONE;
                    end else if (mode) begin
                        state_s = ST_WR;
                    end else begin
                        state_s = ST_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                buf_s   = mem_dataout;
                state_s = ST_WR;
            end
            ST_WR: begin
                src_ptr_s    = src_ptr_r + PTR_ONE;
                dst_ptr_s    = dst_ptr_r + PTR_ONE;
                words_left_s = words_left_r - LEN_ONE;
                if (words_left_r == LEN_ONE) begin
                    state_s = ST_DONE;
                end else if (mode_r) begin
                    state_s = ST_WR;
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every port comes straight from a flop;
    // address and data hold their previous values outside RD/WR.
    always_comb begin
        busy_s       = (state_s != ST_IDLE);
        done_s       = (state_s == ST_DONE);
        mem_write_s  = (state_s == ST_WR);
        mem_addr_s   = mem_addr_r;
        mem_datain_s = mem_datain_r;
        case (state_s)
            ST_RD: begin
                mem_addr_s = src_ptr_s;
            end
            ST_WR: begin
                mem_addr_s   = dst_ptr_s;
                mem_datain_s = mode_s ? fill_s : buf_s;
            end
            default: begin
                mem_addr_s   = mem_addr_r;
                mem_datain_s = mem_datain_r;
            end
        endcase
    end

    // State, pointer and registered-output flops; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            mode_r       <= 1'b0;
            src_ptr_r    <= '0;
            dst_ptr_r    <= '0;
            words_left_r <= '0;
            buf_r        <= '0;
            fill_r       <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= '0;
            mem_datain_r <= '0;
        end else begin
            state_r      <= state_s;
            mode_r       <= mode_s;
            src_ptr_r    <= src_ptr_s;
            dst_ptr_r    <= dst_ptr_s;
            words_left_r <= words_left_s;
            buf_r        <= buf_s;
            fill_r       <= fill_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            mem_write_r  <= mem_write_s;
            mem_addr_r   <= mem_addr_s;
            mem_datain_r <= mem_datain_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign words_left = words_left_r;
    assign mem_write  = mem_write_r;
    assign mem_addr   = mem_addr_r;
    assign mem_datain = mem_datain_r;

endmodule

// File: tb/tb_data_mem_dma.sv
// Directed bench for data_mem_dma with a behavioural 32x16 memory attached to its port.
module tb_data_mem_dma;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [4:0]  src_addr;
    logic [4:0]  dst_addr;
    logic [5:0]  len;
    logic [15:0] fill_value;
    logic        busy;
    logic        done;
    logic [5:0]  words_left;
    logic        mem_write;
    logic [4:0]  mem_addr;
    logic [15:0] mem_datain;
    logic [15:0] mem_dataout;

    logic [15:0] mem [32];

    int n_total;
    int n_pass;
    int busy_n;
    int done_n;
    int done_at;
    int wr_n;
    bit timed_out;

    data_mem_dma dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .words_left (words_left),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_datain (mem_datain),
        .mem_dataout(mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_datain;
    end
    assign mem_dataout = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic launch(input logic m, input logic [4:0] s, input logic [4:0] d,
                          input logic [5:0] l, input logic [15:0] f);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_value = f;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle 1 is the first negedge after the start edge; poke_at drives a stray start.
    task automatic watch(input int budget, input int poke_at);
        busy_n = 0; done_n = 0; done_at = 0; wr_n = 0; timed_out = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = c; end
            if (mem_write) wr_n++;
            if (c == poke_at) begin
                mode = 1'b1; src_addr = 5'd9; dst_addr = 5'd0; len = 6'd5;
                fill_value = 16'hFFFF; start = 1'b1;
            end
            if (!busy && c > 1) begin timed_out = 1'b0; break; end
        end
        start = 1'b0;
        check("watch_timeout", {31'd0, timed_out}, 32'd0);
    endtask

    task automatic test_reset();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        check("rst_mem_datain", {16'd0, mem_datain}, 32'd0);
        check("rst_words_left", {26'd0, words_left}, 32'd0);
    endtask

    task automatic test_copy();
        @(negedge clk);
        mem[0] = 16'd1; mem[1] = 16'd3; mem[2] = 16'd4;
        mem[16] = 16'h0; mem[17] = 16'h0; mem[18] = 16'h0;
        launch(1'b0, 5'd0, 5'd16, 6'd3, 16'h0);
        watch(40, 0);
        check("copy_busy_cycles", busy_n, 32'd7);
        check("copy_done_count", done_n, 32'd1);
        check("copy_done_at", done_at, 32'd7);
        check("copy_writes", wr_n, 32'd3);
        check("copy_m16", {16'd0, mem[16]}, 32'd1);
        check("copy_m17", {16'd0, mem[17]}, 32'd3);
        check("copy_m18", {16'd0, mem[18]}, 32'd4);
        check("copy_words_left", {26'd0, words_left}, 32'd0);
    endtask

    task automatic test_fill();
        @(negedge clk);
        mem[12] = 16'h1212;
        launch(1'b1, 5'd3, 5'd8, 6'd4, 16'hA5A5);
        watch(40, 0);
        check("fill_writes", wr_n, 32'd4);
        check("fill_busy_cycles", busy_n, 32'd5);
        check("fill_done_at", done_at, 32'd5);
        for (int i = 8; i < 12; i++) check("fill_word", {16'd0, mem[i]}, 32'hA5A5);
        check("fill_m12_kept", {16'd0, mem[12]}, 32'h1212);
        check("fill_addr_hold", {27'd0, mem_addr}, 32'd11);
        check("fill_data_hold", {16'd0, mem_datain}, 32'hA5A5);
    endtask

    task automatic test_len_zero();
        for (int m = 0; m < 2; m++) begin
            launch(m[0], 5'd2, 5'd5, 6'd0, 16'h7777);
            watch(20, 0);
            check("len0_writes", wr_n, 32'd0);
            check("len0_busy_cycles", busy_n, 32'd1);
            check("len0_done_at", done_at, 32'd1);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        mem[30] = 16'd30; mem[31] = 16'd0; mem[0] = 16'd1; mem[1] = 16'd3;
        launch(1'b0, 5'd30, 5'd20, 6'd4, 16'h0);
        watch(40, 0);
        check("wrap_m20", {16'd0, mem[20]}, 32'd30);
        check("wrap_m21", {16'd0, mem[21]}, 32'd0);
        check("wrap_m22", {16'd0, mem[22]}, 32'd1);
        check("wrap_m23", {16'd0, mem[23]}, 32'd3);
        check("wrap_busy_cycles", busy_n, 32'd9);
    endtask

    task automatic test_ignore_start();
        @(negedge clk);
        mem[4] = 16'd7; mem[5] = 16'd8; mem[6] = 16'd9; mem[0] = 16'h0101;
        launch(1'b0, 5'd4, 5'd12, 6'd3, 16'h0);
        watch(40, 3);
        check("ign_done_count", done_n, 32'd1);
        check("ign_busy_cycles", busy_n, 32'd7);
        check("ign_m12", {16'd0, mem[12]}, 32'd7);
        check("ign_m13", {16'd0, mem[13]}, 32'd8);
        check("ign_m14", {16'd0, mem[14]}, 32'd9);
        check("ign_m0_kept", {16'd0, mem[0]}, 32'h0101);
    endtask

    task automatic test_start_in_done();
        launch(1'b1, 5'd0, 5'd28, 6'd2, 16'h5A5A);
        watch(40, 3);
        check("sid_busy_cycles", busy_n, 32'd3);
        check("sid_writes", wr_n, 32'd2);
        repeat (3) @(negedge clk);
        check("sid_idle_busy", {31'd0, busy}, 32'd0);
        check("sid_m0_kept", {16'd0, mem[0]}, 32'h0101);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        for (int i = 0; i < 10; i++) mem[i] = 16'(100 + i);
        for (int i = 24; i < 32; i++) mem[i] = 16'hDEAD;
        launch(1'b0, 5'd0, 5'd24, 6'd10, 16'h0);
        repeat (6) @(negedge clk);
        check("mr_in_wr3", {31'd0, mem_write}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_write_drop", {31'd0, mem_write}, 32'd0);
        check("mr_busy_drop", {31'd0, busy}, 32'd0);
        check("mr_words_left", {26'd0, words_left}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("mr_m24", {16'd0, mem[24]}, 32'd100);
        check("mr_m25", {16'd0, mem[25]}, 32'd101);
        check("mr_m26_kept", {16'd0, mem[26]}, 32'hDEAD);
        launch(1'b0, 5'd2, 5'd26, 6'd2, 16'h0);
        watch(40, 0);
        check("mr_after_busy", busy_n, 32'd5);
        check("mr_after_m26", {16'd0, mem[26]}, 32'd102);
        check("mr_after_m27", {16'd0, mem[27]}, 32'd103);
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0;
        src_addr = 5'd0; dst_addr = 5'd0; len = 6'd0; fill_value = 16'h0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_copy();
        test_fill();
        test_len_zero();
        test_wrap();
        test_ignore_start();
        test_start_in_done();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
